// File: rtl/pwm_compare_stage_if.sv
// Duty-write bus between the MMIO side (master) and the PWM compare stage (slave).
interface pwm_compare_stage_if #(
   parameter int WIDTH = 8
);
   logic             wr_en;
   logic [WIDTH-1:0] wr_data;
   logic             wr_ack;
   logic             update_pending;

   modport master (
      output wr_en,
      output wr_data,
      input  wr_ack,
      input  update_pending
   );

   modport slave (
      input  wr_en,
      input  wr_data,
      output wr_ack,
      output update_pending
   );
endinterface

// File: rtl/pwm_compare_stage.sv
// PWM compare stage: double-buffered duty register loaded at period boundaries,
// registered compare of the upstream counter value against the active duty.
module pwm_compare_stage #(
   parameter int WIDTH      = 8,
   parameter int PERIOD_MAX = 255,
   parameter int DUTY_RESET = 0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     tick,
   input  logic                 enable,
   pwm_compare_stage_if.slave   wr_bus,
   output logic [WIDTH-1:0]     duty_active,
   output logic                 period_done,
   output logic                 pwm_out
);

   localparam logic [WIDTH-1:0] PERIOD_MAX_V = WIDTH'(PERIOD_MAX);
   localparam logic [WIDTH-1:0] DUTY_RESET_V = WIDTH'(DUTY_RESET);

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } state_t;

   state_t           state_r;
   state_t           next_state_s;
   logic             boundary_s;
   logic [WIDTH-1:0] duty_pending_r;
   logic [WIDTH-1:0] duty_pending_s;
   logic [WIDTH-1:0] duty_active_r;
   logic [WIDTH-1:0] duty_active_s;
   logic             pwm_next_s;
   logic             wr_ack_r;
   logic             update_pending_r;
   logic             period_done_r;
   logic             pwm_out_r;

   // Values above PERIOD_MAX are ordinary compare values, only an exact match is a boundary.
   assign boundary_s = (tick == PERIOD_MAX_V);

   // FSM state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // FSM next-state: a write on the boundary is applied immediately, so it never pends
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (wr_bus.wr_en && !boundary_s) begin
               next_state_s = ST_PENDING;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_PENDING: begin
            if (boundary_s) begin
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_PENDING;
            end
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // Duty buffer next values: last write wins, load only at the boundary
   always_comb begin
      duty_pending_s = duty_pending_r;
      duty_active_s  = duty_active_r;
      if (wr_bus.wr_en) begin
         duty_pending_s = wr_bus.wr_data;
      end else begin
         duty_pending_s = duty_pending_r;
      end
      if (boundary_s) begin
         duty_active_s = wr_bus.wr_en ? wr_bus.wr_data : duty_pending_r;
      end else begin
         duty_active_s = duty_active_r;
      end
   end

   // Compare uses the duty that was active when this tick was sampled
   always_comb begin
      pwm_next_s = 1'b0;
      if (enable) begin
         pwm_next_s = (tick < duty_active_r);
      end else begin
         pwm_next_s = 1'b0;
      end
   end

   // Duty buffer registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         duty_pending_r <= DUTY_RESET_V;
         duty_active_r  <= DUTY_RESET_V;
      end else begin
         duty_pending_r <= duty_pending_s;
         duty_active_r  <= duty_active_s;
      end
   end

   // Registered status and waveform outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ack_r         <= 1'b0;
         update_pending_r <= 1'b0;
         period_done_r    <= 1'b0;
         pwm_out_r        <= 1'b0;
      end else begin
         wr_ack_r         <= wr_bus.wr_en;
         update_pending_r <= (next_state_s == ST_PENDING);
         period_done_r    <= boundary_s;
         pwm_out_r        <= pwm_next_s;
      end
   end

   assign wr_bus.wr_ack         = wr_ack_r;
   assign wr_bus.update_pending = update_pending_r;
   assign duty_active           = duty_active_r;
   assign period_done           = period_done_r;
   assign pwm_out               = pwm_out_r;

endmodule

// File: tb/tb_pwm_compare_stage.sv
// Self-checking bench for pwm_compare_stage: per-cycle scoreboard plus scenario checks.
module tb_pwm_compare_stage;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] tick = 8'd0;
   logic       enable = 1'b1;
   logic [7:0] duty_active;
   logic       period_done;
   logic       pwm_out;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic       ack;
      logic       upd;
      logic       pd;
      logic       pwm;
      logic [7:0] act;
   } exp_t;

   exp_t sb[$];

   // reference state for the scoreboard
   logic [7:0] m_active  = 8'd0;
   logic [7:0] m_pending = 8'd0;
   logic       m_upd     = 1'b0;

   pwm_compare_stage_if #(.WIDTH(8)) wr_bus ();

   pwm_compare_stage #(
      .WIDTH(8),
      .PERIOD_MAX(255),
      .DUTY_RESET(0)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .tick       (tick),
      .enable     (enable),
      .wr_bus     (wr_bus),
      .duty_active(duty_active),
      .period_done(period_done),
      .pwm_out    (pwm_out)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // One clock: predict outputs from current inputs, advance, compare, step the counter.
   task automatic step();
      exp_t e;
      exp_t got;
      logic b;
      b     = (tick == 8'd255);
      e.ack = wr_bus.wr_en;
      e.pd  = b;
      e.pwm = enable && (tick < m_active);
      if (b) begin
         m_active = wr_bus.wr_en ? wr_bus.wr_data : m_pending;
         m_upd    = 1'b0;
      end else if (wr_bus.wr_en) begin
         m_upd = 1'b1;
      end
      if (wr_bus.wr_en) m_pending = wr_bus.wr_data;
      e.upd = m_upd;
      e.act = m_active;
      sb.push_back(e);
      @(posedge clock);
      #1;
      got = sb.pop_front();
      checks++;
      if (wr_bus.wr_ack !== got.ack) begin
         errors++;
         $display("FAIL sb_wr_ack tick=%0d: got %b expected %b", tick, wr_bus.wr_ack, got.ack);
      end
      checks++;
      if (wr_bus.update_pending !== got.upd) begin
         errors++;
         $display("FAIL sb_update_pending tick=%0d: got %b expected %b", tick, wr_bus.update_pending, got.upd);
      end
      checks++;
      if (period_done !== got.pd) begin
         errors++;
         $display("FAIL sb_period_done tick=%0d: got %b expected %b", tick, period_done, got.pd);
      end
      checks++;
      if (pwm_out !== got.pwm) begin
         errors++;
         $display("FAIL sb_pwm_out tick=%0d: got %b expected %b", tick, pwm_out, got.pwm);
      end
      checks++;
      if (duty_active !== got.act) begin
         errors++;
         $display("FAIL sb_duty_active tick=%0d: got %0d expected %0d", tick, duty_active, got.act);
      end
      tick         = tick + 8'd1;
      wr_bus.wr_en = 1'b0;
   endtask

   task automatic run_to(input logic [7:0] t);
      for (int i = 0; i < 256 && tick != t; i++) step();
   endtask

   task automatic test_reset();
      int highs;
      int pds;
      #23;
      checks++;
      if ({pwm_out, wr_bus.wr_ack, wr_bus.update_pending, period_done} !== 4'b0000 || duty_active !== 8'd0) begin
         errors++;
         $display("FAIL reset_state: got pwm/ack/upd/pd=%b%b%b%b duty=%0d expected 0000 duty=0",
                  pwm_out, wr_bus.wr_ack, wr_bus.update_pending, period_done, duty_active);
      end
      @(negedge clock);
      reset = 1'b1;
      highs = 0;
      pds   = 0;
      for (int i = 0; i < 512; i++) begin
         step();
         highs += int'(pwm_out);
         pds   += int'(period_done);
      end
      checks++;
      if (highs != 0) begin
         errors++;
         $display("FAIL idle_pwm_high_count: got %0d expected 0", highs);
      end
      checks++;
      if (pds != 2) begin
         errors++;
         $display("FAIL idle_period_done_count: got %0d expected 2", pds);
      end
   endtask

   task automatic test_write_load();
      int highs;
      run_to(8'd10);
      wr_bus.wr_en   = 1'b1;
      wr_bus.wr_data = 8'd64;
      step();
      checks++;
      if (wr_bus.wr_ack !== 1'b1 || wr_bus.update_pending !== 1'b1) begin
         errors++;
         $display("FAIL write64_ack_pending: got ack=%b upd=%b expected 1 1", wr_bus.wr_ack, wr_bus.update_pending);
      end
      run_to(8'd0);
      checks++;
      if (duty_active !== 8'd64 || wr_bus.update_pending !== 1'b0) begin
         errors++;
         $display("FAIL write64_loaded: got duty=%0d upd=%b expected 64 0", duty_active, wr_bus.update_pending);
      end
      highs = 0;
      for (int i = 0; i < 256; i++) begin
         step();
         highs += int'(pwm_out);
      end
      checks++;
      if (highs != 64) begin
         errors++;
         $display("FAIL write64_high_count: got %0d expected 64", highs);
      end
   endtask

   task automatic test_last_write_wins();
      int acks;
      run_to(8'd100);
      wr_bus.wr_en   = 1'b1;
      wr_bus.wr_data = 8'd200;
      acks = 0;
      for (int i = 0; i < 257 && !(i > 0 && tick == 8'd0); i++) begin
         if (tick == 8'd150) begin
            wr_bus.wr_en   = 1'b1;
            wr_bus.wr_data = 8'd30;
         end
         step();
         acks += int'(wr_bus.wr_ack);
      end
      checks++;
      if (acks != 2) begin
         errors++;
         $display("FAIL double_write_ack_count: got %0d expected 2", acks);
      end
      checks++;
      if (duty_active !== 8'd30) begin
         errors++;
         $display("FAIL double_write_loaded: got %0d expected 30", duty_active);
      end
   endtask

   task automatic test_boundary_write();
      run_to(8'd255);
      wr_bus.wr_en   = 1'b1;
      wr_bus.wr_data = 8'd128;
      step();
      checks++;
      if (duty_active !== 8'd128 || wr_bus.update_pending !== 1'b0 || wr_bus.wr_ack !== 1'b1) begin
         errors++;
         $display("FAIL boundary_write: got duty=%0d upd=%b ack=%b expected 128 0 1",
                  duty_active, wr_bus.update_pending, wr_bus.wr_ack);
      end
      step();
      checks++;
      if (wr_bus.update_pending !== 1'b0) begin
         errors++;
         $display("FAIL boundary_write_no_pending: got %b expected 0", wr_bus.update_pending);
      end
   endtask

   task automatic test_duty_255_enable();
      int highs;
      run_to(8'd255);
      wr_bus.wr_en   = 1'b1;
      wr_bus.wr_data = 8'd255;
      step();
      highs = 0;
      for (int i = 0; i < 256; i++) begin
         enable = (tick < 8'd20) || (tick > 8'd40);
         step();
         highs += int'(pwm_out);
      end
      enable = 1'b1;
      checks++;
      if (highs != 234) begin
         errors++;
         $display("FAIL duty255_gated_high_count: got %0d expected 234", highs);
      end
      highs = 0;
      for (int i = 0; i < 256; i++) begin
         step();
         highs += int'(pwm_out);
      end
      checks++;
      if (highs != 255) begin
         errors++;
         $display("FAIL duty255_high_count: got %0d expected 255", highs);
      end
   endtask

   task automatic test_reset_mid_pending();
      int highs;
      run_to(8'd40);
      wr_bus.wr_en   = 1'b1;
      wr_bus.wr_data = 8'd77;
      step();
      run_to(8'd50);
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({pwm_out, wr_bus.wr_ack, wr_bus.update_pending, period_done} !== 4'b0000 || duty_active !== 8'd0) begin
         errors++;
         $display("FAIL midreset_outputs: got pwm/ack/upd/pd=%b%b%b%b duty=%0d expected 0000 duty=0",
                  pwm_out, wr_bus.wr_ack, wr_bus.update_pending, period_done, duty_active);
      end
      m_active  = 8'd0;
      m_pending = 8'd0;
      m_upd     = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      run_to(8'd0);
      checks++;
      if (duty_active !== 8'd0) begin
         errors++;
         $display("FAIL midreset_pending_lost: got %0d expected 0", duty_active);
      end
      highs = 0;
      for (int i = 0; i < 256; i++) begin
         step();
         highs += int'(pwm_out);
      end
      checks++;
      if (highs != 0) begin
         errors++;
         $display("FAIL midreset_high_count: got %0d expected 0", highs);
      end
   endtask

   initial begin
      wr_bus.wr_en   = 1'b0;
      wr_bus.wr_data = 8'd0;
      test_reset();
      test_write_load();
      test_last_write_wins();
      test_boundary_write();
      test_duty_255_enable();
      test_reset_mid_pending();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
